neo_mem_engine: RTL

- Initiator/master for the single-port-pair sample memory (registered read, write gated by address).
- On `start`, streams a block of signed samples out of memory.
- Computes the nonlinear energy operator psi[n] = x[n]^2 - x[n-1]*x[n+1] for each interior sample, then scales and saturates each result.
- Writes the results back into a separate output region of the same memory.
- Sits between the sample-capture path and the spike-detection logic.

---
 rtl/neo_mem_engine.sv | 137 +++++++++++++
 1 files changed

// File: rtl/neo_mem_engine.sv
// Streams a block of signed samples from memory, computes the nonlinear energy
// operator x[n]^2 - x[n-1]*x[n+1], scales/saturates it and writes it back.
module neo_mem_engine #(
  parameter int N            = 16,
  parameter int M            = 32,
  parameter int SRC_BASE     = 0,
  parameter int LEN          = 16,
  parameter int OUT_BASE     = 16,
  parameter int SCRATCH_ADDR = M - 1,
  parameter int SHIFT        = N - 1,
  localparam int AW          = $clog2(M)
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                sat_flag,
  output logic [AW-1:0]       raddr,
  input  logic signed [N-1:0] rdata,
  output logic [AW-1:0]       waddr,
  output logic signed [N-1:0] wdata,
  output logic                mem_we
);

  // Valid/ready note: there is no backpressure; start is a request honoured only
  // in IDLE, and each presented (mem_we, waddr, wdata) is committed at the next edge.

  localparam int CW = $clog2(LEN + 4) + 1;
  localparam int W2 = 2 * N + 1;

  localparam logic [CW-1:0] CNT_LAST_RD = CW'(LEN - 2);
  localparam logic [CW-1:0] CNT_WR_LO   = CW'(3);
  localparam logic [CW-1:0] CNT_WR_HI   = CW'(LEN);
  localparam logic [CW-1:0] CNT_END     = CW'(LEN + 1);
  localparam logic [AW-1:0] SCRATCH     = AW'(SCRATCH_ADDR);
  localparam logic [AW-1:0] SRC_A       = AW'(SRC_BASE);

  localparam logic signed [W2-1:0] MAXV = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [W2-1:0] MINV = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} state_t;

  state_t state, state_n;

  logic [CW-1:0]       cnt;
  logic signed [N-1:0] x_prev, x_mid;

  logic signed [W2-1:0] xp, xm, xr, psi, scaled;
  logic signed [N-1:0]  res;
  logic                 clamp;

  always_ff @(posedge Clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt == CNT_LAST_RD) state_n = DRAIN;
      DRAIN:   if (cnt == CNT_END) state_n = DONE_S;
      DONE_S:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Window ends at the sample currently on rdata; x_mid is the centre sample.
  always_comb begin
    xp     = W2'(x_prev);
    xm     = W2'(x_mid);
    xr     = W2'(rdata);
    psi    = xm * xm - xp * xr;
    scaled = psi >>> SHIFT;
    res    = scaled[N-1:0];
    clamp  = 1'b0;
    if (scaled > MAXV) begin
      res   = MAXV[N-1:0];
      clamp = 1'b1;
    end else if (scaled < MINV) begin
      res   = MINV[N-1:0];
      clamp = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      raddr    <= '0;
      waddr    <= SCRATCH;
      wdata    <= '0;
      mem_we   <= 1'b0;
      cnt      <= '0;
      x_prev   <= '0;
      x_mid    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            sat_flag <= 1'b0;
            raddr    <= SRC_A;
            cnt      <= '0;
            x_prev   <= '0;
            x_mid    <= '0;
          end
        end
        RUN, DRAIN: begin
          cnt    <= cnt + 1'b1;
          x_prev <= x_mid;
          x_mid  <= rdata;
          if (state == RUN) raddr <= AW'(SRC_BASE + 32'(cnt) + 1);
          if (cnt >= CNT_WR_LO && cnt <= CNT_WR_HI) begin
            mem_we <= 1'b1;
            waddr  <= AW'(OUT_BASE + 32'(cnt) - 3);
            wdata  <= res;
            if (clamp) sat_flag <= 1'b1;
          end else begin
            mem_we <= 1'b0;
            waddr  <= SCRATCH;
            wdata  <= '0;
          end
          if (state == DRAIN && cnt == CNT_END) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
